// File: rtl/propose_integer_in_range.sv
// Proposes a random signed integer strictly between two optional bounds using
// LFSR-driven rejection sampling, with a deterministic fallback after MAX_ATTEMPTS tries.
module propose_integer_in_range #(
    parameter int          NUMBER_SIZE  = 8,
    parameter int          MAX_ATTEMPTS = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic                          in_start,
    input  logic signed [NUMBER_SIZE-1:0] in_c1,
    input  logic                          in_c1_active,
    input  logic signed [NUMBER_SIZE-1:0] in_c2,
    input  logic                          in_c2_active,
    input  logic signed [NUMBER_SIZE-1:0] in_current_value,
    output logic signed [NUMBER_SIZE-1:0] out_value,
    output logic                          out_valid,
    output logic                          out_empty,
    output logic                          out_fallback,
    output logic                          out_busy
);

    localparam int W           = NUMBER_SIZE;
    localparam int E           = NUMBER_SIZE + 1;
    localparam int SMEAR_STEPS = $clog2(W);

    localparam logic signed [E-1:0] MIN_VAL = {2'b11, {(W-1){1'b0}}};
    localparam logic signed [E-1:0] MAX_VAL = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [E-1:0] ONE_E   = {{W{1'b0}}, 1'b1};
    localparam logic [3:0]          K_LAST  = 4'(MAX_ATTEMPTS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, DONE} state_t;

    state_t                state_reg, state_next;
    logic [15:0]           lfsr_reg, lfsr_next;
    logic [3:0]            k_reg;
    logic signed [W-1:0]   c1_reg, c2_reg, current_reg;
    logic                  c1_active_reg, c2_active_reg;
    logic [W-1:0]          low_reg, span_reg, mask_reg;
    logic [W-1:0]          value_reg;
    logic                  empty_reg, fallback_reg;

    logic signed [E-1:0]   low_calc, high_calc;
    logic                  empty_calc;
    logic [W-1:0]          span_calc, mask_calc;
    logic [W-1:0]          smear [0:SMEAR_STEPS];
    logic [W-1:0]          candidate, fallback_candidate;
    logic                  fits;

    // Bounds widened by one bit so C2+1 and C1-1 never wrap at the type limits.
    assign low_calc   = in_range_low(c2_active_reg, c2_reg);
    assign high_calc  = c1_active_reg ? $signed({c1_reg[W-1], c1_reg}) - ONE_E : MAX_VAL;
    assign empty_calc = high_calc < low_calc;
    // A non-empty span lies in 0..2^W-1, so modulo-2^W subtraction is exact.
    assign span_calc  = high_calc[W-1:0] - low_calc[W-1:0];

    function automatic logic signed [E-1:0] in_range_low(input logic active,
                                                         input logic signed [W-1:0] c2);
        return active ? $signed({c2[W-1], c2}) + ONE_E : MIN_VAL;
    endfunction

    // Smear the span's leading one downward to get the smallest 2^k-1 covering it.
    assign smear[0] = span_calc;
    generate
        for (genvar gi = 0; gi < SMEAR_STEPS; gi++) begin : g_smear
            assign smear[gi+1] = smear[gi] | (smear[gi] >> (1 << gi));
        end
    endgenerate
    assign mask_calc = smear[SMEAR_STEPS];

    assign lfsr_next          = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign candidate          = lfsr_reg[W-1:0] & mask_reg;
    assign fallback_candidate = candidate & (mask_reg >> 1);
    assign fits               = candidate <= span_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_start) state_next = SETUP;
            SETUP:   state_next = empty_calc ? DONE : SAMPLE;
            SAMPLE:  if (fits || (k_reg == K_LAST)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_reg     <= IDLE;
            lfsr_reg      <= LFSR_SEED;
            k_reg         <= '0;
            c1_reg        <= '0;
            c2_reg        <= '0;
            current_reg   <= '0;
            c1_active_reg <= 1'b0;
            c2_active_reg <= 1'b0;
            low_reg       <= '0;
            span_reg      <= '0;
            mask_reg      <= '0;
            value_reg     <= '0;
            empty_reg     <= 1'b0;
            fallback_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            case (state_reg)
                IDLE: begin
                    if (in_start) begin
                        c1_reg        <= in_c1;
                        c2_reg        <= in_c2;
                        current_reg   <= in_current_value;
                        c1_active_reg <= in_c1_active;
                        c2_active_reg <= in_c2_active;
                        k_reg         <= '0;
                    end
                end
                SETUP: begin
                    low_reg  <= low_calc[W-1:0];
                    span_reg <= span_calc;
                    mask_reg <= mask_calc;
                    if (empty_calc) begin
                        value_reg    <= current_reg;
                        empty_reg    <= 1'b1;
                        fallback_reg <= 1'b0;
                    end
                end
                SAMPLE: begin
                    // Results fit in W bits, so the additions can wrap harmlessly.
                    if (fits) begin
                        value_reg    <= low_reg + candidate;
                        empty_reg    <= 1'b0;
                        fallback_reg <= 1'b0;
                    end else if (k_reg == K_LAST) begin
                        value_reg    <= low_reg + fallback_candidate;
                        empty_reg    <= 1'b0;
                        fallback_reg <= 1'b1;
                    end else begin
                        k_reg <= k_reg + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_value    = value_reg;
    assign out_empty    = empty_reg;
    assign out_fallback = fallback_reg;
    assign out_valid    = (state_reg == DONE);
    assign out_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_propose_integer_in_range.sv
// Scoreboard bench: two instances (default attempts and a single attempt) share
// stimulus; expected results come from an independent LFSR/rejection model.
module tb_propose_integer_in_range;

    typedef struct {
        logic [7:0] val;
        bit         empty;
        bit         fb;
        int         cyc;
        int         lo;
        int         hi;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [7:0] c1, c2, cur;
    logic              c1a, c2a;
    logic [7:0]        v0, v1;
    logic              val0, emp0, fb0, busy0;
    logic              val1, emp1, fb1, busy1;

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] m_lfsr   = 16'hACE1;
    bit          rst_edge = 1'b1;
    logic [7:0]  last_v[2];
    bit          last_e[2];
    bit          last_f[2];

    always #5 clk = ~clk;

    propose_integer_in_range dut0 (
        .in_clk(clk), .in_reset(rst), .in_start(start),
        .in_c1(c1), .in_c1_active(c1a), .in_c2(c2), .in_c2_active(c2a),
        .in_current_value(cur),
        .out_value(v0), .out_valid(val0), .out_empty(emp0),
        .out_fallback(fb0), .out_busy(busy0)
    );

    propose_integer_in_range #(.MAX_ATTEMPTS(1)) dut1 (
        .in_clk(clk), .in_reset(rst), .in_start(start),
        .in_c1(c1), .in_c1_active(c1a), .in_c2(c2), .in_c2_active(c2a),
        .in_current_value(cur),
        .out_value(v1), .out_valid(val1), .out_empty(emp1),
        .out_fallback(fb1), .out_busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic void predict(input logic signed [7:0] pc1, input logic pc1a,
                                    input logic signed [7:0] pc2, input logic pc2a,
                                    input logic signed [7:0] pcur, input logic [15:0] lfsr_now,
                                    input int max_att, input int base, output exp_t e);
        int lo, hi, span, mask, cand;
        logic [15:0] l;
        e.val = 8'h00; e.empty = 0; e.fb = 0; e.cyc = 0;
        lo = pc2a ? int'(pc2) + 1 : -128;
        hi = pc1a ? int'(pc1) - 1 : 127;
        e.lo = lo; e.hi = hi;
        if (hi < lo) begin
            e.val = pcur; e.empty = 1; e.cyc = base + 2;
            return;
        end
        span = hi - lo;
        mask = 0;
        while (mask < span) mask = mask * 2 + 1;
        l = lfsr_step(lfsr_step(lfsr_now));
        for (int j = 0; j < max_att; j++) begin
            cand = int'(l[7:0]) & mask;
            if (cand <= span) begin
                e.val = 8'(lo + cand); e.cyc = base + 3 + j;
                return;
            end
            if (j == max_att - 1) begin
                e.val = 8'(lo + (cand & (mask >> 1))); e.fb = 1; e.cyc = base + 3 + j;
                return;
            end
            l = lfsr_step(l);
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
        m_lfsr   = rst ? 16'hACE1 : lfsr_step(m_lfsr);
    end

    task automatic observe(input int idx, input logic [7:0] v, input logic valid,
                           input logic empty, input logic fb, input logic busy);
        exp_t e;
        bit   have;
        if (rst_edge) begin
            check($sformatf("reset_outputs%0d", idx), {v, valid, empty, fb, busy}, 0);
            last_v[idx] = 0; last_e[idx] = 0; last_f[idx] = 0;
        end else if (valid) begin
            have = (idx == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                check($sformatf("spurious_valid%0d", idx), 1, 0);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check($sformatf("value%0d", idx), v, e.val);
                check($sformatf("empty%0d", idx), empty, e.empty);
                check($sformatf("fallback%0d", idx), fb, e.fb);
                check($sformatf("latency%0d", idx), cyc, e.cyc);
                check($sformatf("busy_at_valid%0d", idx), busy, 1);
                if (!e.empty)
                    check($sformatf("in_range%0d", idx),
                          (int'($signed(v)) >= e.lo) && (int'($signed(v)) <= e.hi), 1);
                $display("dut%0d value=%0d empty=%0b fallback=%0b cycle=%0d",
                         idx, $signed(v), empty, fb, cyc);
                last_v[idx] = v; last_e[idx] = empty; last_f[idx] = fb;
            end
        end else begin
            check($sformatf("hold%0d", idx), {v, empty, fb}, {last_v[idx], last_e[idx], last_f[idx]});
        end
    endtask

    always @(negedge clk) begin
        observe(0, v0, val0, emp0, fb0, busy0);
        observe(1, v1, val1, emp1, fb1, busy1);
    end

    task automatic request(input logic signed [7:0] rc1, input logic rc1a,
                           input logic signed [7:0] rc2, input logic rc2a,
                           input logic signed [7:0] rcur, input bit poke);
        exp_t e;
        int   waited;
        @(negedge clk);
        c1 = rc1; c1a = rc1a; c2 = rc2; c2a = rc2a; cur = rcur; start = 1'b1;
        predict(rc1, rc1a, rc2, rc2a, rcur, m_lfsr, 8, cyc, e); q0.push_back(e);
        predict(rc1, rc1a, rc2, rc2a, rcur, m_lfsr, 1, cyc, e); q1.push_back(e);
        @(negedge clk);
        check("busy_after_start", {busy0, busy1}, 2'b11);
        if (poke) begin
            // A second start with different inputs while busy must change nothing.
            c1 = ~rc1; c2 = ~rc2; cur = ~rcur; c1a = ~rc1a; c2a = ~rc2a;
            @(negedge clk);
        end
        start = 1'b0;
        waited = 0;
        while ((busy0 || busy1) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (busy0 || busy1) check("completion_timeout", 1, 0);
        check("queue_drained", q0.size() + q1.size(), 0);
        q0.delete(); q1.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        c1 = 0; c2 = 0; cur = 0; c1a = 0; c2a = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        request(8'sd5,    1, 8'sd3,    1, 8'sd0,   0);
        request(8'sd3,    1, 8'sd3,    1, -8'sd7,  0);
        request(8'sd0,    0, 8'sd127,  1, 8'sd55,  0);
        request(-8'sd128, 1, 8'sd0,    0, -8'sd3,  0);
        request(-8'sd127, 1, -8'sd128, 1, 8'sd9,   0);
        request(8'sd127,  1, -8'sd128, 1, 8'sd0,   0);
        request(8'sd20,   1, 8'sd1,    1, 8'sd0,   1);
        request(8'sd4,    1, 8'sd4,    1, 8'sd33,  1);
        for (int i = 0; i < 40; i++) request(8'sd10, 1, -8'sd1, 1, 8'sd0, 0);
        for (int i = 0; i < 200; i++)
            request(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), 0);

        // Reset while the instances sit in SAMPLE: the request must vanish.
        @(negedge clk);
        c1 = 8'sd100; c1a = 1; c2 = -8'sd100; c2a = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("in_sample_before_reset", {busy0, busy1}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy0, busy1}, 2'b00);
        request(8'sd50, 1, 8'sd10, 1, 8'sd0, 0);

        for (int i = 0; i < 1000; i++) request(8'sd0, 0, 8'sd0, 0, 8'sd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
